// File: rtl/alu_result_stage.sv
// Execute/memory boundary register: decodes ALU outputs into a writeback record,
// resolves bne/blt redirects, and buffers records in a main + skid pair.
module alu_result_stage #(
   parameter int DATA_W      = 32,
   parameter int REG_W       = 5,
   parameter int RSTATUS_REG = 30
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_result,
   input  logic              in_ne,
   input  logic              in_lt,
   input  logic              in_ovf,
   input  logic [4:0]        in_opcode,
   input  logic [4:0]        in_aluop,
   input  logic [REG_W-1:0]  in_rd,
   input  logic [DATA_W-1:0] in_pc,
   input  logic [DATA_W-1:0] in_imm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic [REG_W-1:0]  out_rd,
   output logic              out_we,
   output logic              br_taken,
   output logic [DATA_W-1:0] br_target
);

   localparam logic [4:0] OP_RTYPE = 5'b00000;
   localparam logic [4:0] OP_ADDI  = 5'b00101;
   localparam logic [4:0] OP_BNE   = 5'b00010;
   localparam logic [4:0] OP_BLT   = 5'b00110;
   localparam logic [4:0] ALU_ADD  = 5'b00000;
   localparam logic [4:0] ALU_SUB  = 5'b00001;

   typedef struct packed {
      logic [DATA_W-1:0] result;
      logic [REG_W-1:0]  rd;
      logic              we;
   } rec_t;

   // Overflow on add/sub/addi becomes a write of an exception code into $rstatus.
   function automatic rec_t decode_rec(
      input logic [4:0]        opcode,
      input logic [4:0]        aluop,
      input logic              ovf,
      input logic [REG_W-1:0]  rd,
      input logic [DATA_W-1:0] result
   );
      rec_t r;
      logic redirect;
      r.result = result;
      r.rd     = rd;
      r.we     = 1'b0;
      redirect = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            r.we = 1'b1;
            if (ovf && (aluop == ALU_ADD)) begin
               r.rd     = REG_W'(RSTATUS_REG);
               r.result = DATA_W'(32'd1);
               redirect = 1'b1;
            end else if (ovf && (aluop == ALU_SUB)) begin
               r.rd     = REG_W'(RSTATUS_REG);
               r.result = DATA_W'(32'd3);
               redirect = 1'b1;
            end else begin
               redirect = 1'b0;
            end
         end
         OP_ADDI: begin
            r.we = 1'b1;
            if (ovf) begin
               r.rd     = REG_W'(RSTATUS_REG);
               r.result = DATA_W'(32'd2);
               redirect = 1'b1;
            end else begin
               redirect = 1'b0;
            end
         end
         default: begin
            r.we = 1'b0;
         end
      endcase
      if ((rd == '0) && !redirect) begin
         r.we = 1'b0;
      end else begin
         r.we = r.we;
      end
      return r;
   endfunction

   rec_t              main_q, main_d;
   rec_t              skid_q, skid_d;
   logic              main_valid_q, main_valid_d;
   logic              skid_valid_q, skid_valid_d;
   logic              in_ready_q, in_ready_d;
   logic              br_taken_q, br_taken_d;
   logic [DATA_W-1:0] br_target_q, br_target_d;

   logic              accept_s;
   logic              drain_s;
   logic              taken_s;
   rec_t              dec_s;

   assign accept_s = in_valid && in_ready_q && !flush;
   assign drain_s  = main_valid_q && out_ready;
   assign taken_s  = ((in_opcode == OP_BNE) && in_ne) || ((in_opcode == OP_BLT) && in_lt);
   assign dec_s    = decode_rec(in_opcode, in_aluop, in_ovf, in_rd, in_result);

   // Next-state for the main/skid pair, ready flag and branch redirect.
   always_comb begin
      main_d       = main_q;
      skid_d       = skid_q;
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      br_taken_d   = 1'b0;
      br_target_d  = br_target_q;

      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (drain_s) begin
         // Accept never coincides with a full skid because ready is then low.
         if (skid_valid_q) begin
            main_d       = skid_q;
            main_valid_d = 1'b1;
            skid_valid_d = 1'b0;
         end else if (accept_s) begin
            main_d       = dec_s;
            main_valid_d = 1'b1;
         end else begin
            main_valid_d = 1'b0;
         end
      end else if (accept_s) begin
         if (!main_valid_q) begin
            main_d       = dec_s;
            main_valid_d = 1'b1;
         end else begin
            skid_d       = dec_s;
            skid_valid_d = 1'b1;
         end
      end else begin
         main_valid_d = main_valid_q;
      end

      if (accept_s && taken_s) begin
         br_taken_d  = 1'b1;
         br_target_d = in_pc + DATA_W'(32'd1) + in_imm;
      end else begin
         br_taken_d  = 1'b0;
      end

      in_ready_d = !skid_valid_d;
   end

   // State registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         main_q       <= '0;
         skid_q       <= '0;
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b1;
         br_taken_q   <= 1'b0;
         br_target_q  <= '0;
      end else begin
         main_q       <= main_d;
         skid_q       <= skid_d;
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         in_ready_q   <= in_ready_d;
         br_taken_q   <= br_taken_d;
         br_target_q  <= br_target_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign out_valid  = main_valid_q;
   assign out_result = main_q.result;
   assign out_rd     = main_q.rd;
   assign out_we     = main_q.we;
   assign br_taken   = br_taken_q;
   assign br_target  = br_target_q;

endmodule
